// File: rtl/tank_tune_ctrl.sv
// LC-tank capacitor-bank tuner: sweeps every cap code, samples the detected
// amplitude after a settling wait, and locks onto the code with the highest peak.
module tank_tune_ctrl #(
    parameter int CODE_W  = 5,
    parameter int AMP_W   = 10,
    parameter int SETTLE  = 16,
    parameter int MIN_AMP = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              adc_ack,
    input  logic [AMP_W-1:0]  adc_data,
    output logic              adc_req,
    output logic [CODE_W-1:0] cap_code,
    output logic [CODE_W-1:0] best_code,
    output logic [AMP_W-1:0]  best_amp,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_EVAL   = 3'd3,
        S_LOCK   = 3'd4
    } state_t;

    localparam logic [CODE_W-1:0] CODE_MAX    = '1;
    localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [31:0]       MIN_AMP_U   = 32'(MIN_AMP);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] cap_q, cap_d;
    logic [CODE_W-1:0] bc_q, bc_d;
    logic [AMP_W-1:0]  ba_q, ba_d;
    logic [AMP_W-1:0]  samp_q, samp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;

    logic [CODE_W-1:0] bc_n;
    logic [AMP_W-1:0]  ba_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            bc_q    <= '0;
            ba_q    <= '0;
            samp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            bc_q    <= bc_d;
            ba_q    <= ba_d;
            samp_q  <= samp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    // Strictly-greater update keeps the lowest code on amplitude ties.
    always_comb begin
        ba_n = ba_q;
        bc_n = bc_q;
        if (samp_q > ba_q) begin
            ba_n = samp_q;
            bc_n = cap_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        bc_d    = bc_q;
        ba_d    = ba_q;
        samp_d  = samp_q;
        busy_d  = busy_q;
        done_d  = done_q;
        fail_d  = fail_q;
        if (busy_q && abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            fail_d  = 1'b0;
            cap_d   = bc_q;
        end else begin
            case (state_q)
                S_IDLE, S_LOCK: begin
                    if (start) begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                        cap_d   = '0;
                        bc_d    = '0;
                        ba_d    = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        fail_d  = 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 8'd0) state_d = S_SAMPLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                S_SAMPLE: begin
                    if (adc_ack) begin
                        samp_d  = adc_data;
                        state_d = S_EVAL;
                    end
                end
                S_EVAL: begin
                    ba_d = ba_n;
                    bc_d = bc_n;
                    if (cap_q != CODE_MAX) begin
                        cap_d   = cap_q + 1'b1;
                        cnt_d   = SETTLE_LOAD;
                        state_d = S_SETTLE;
                    end else begin
                        // Lock decision uses the amplitude just updated by this EVAL.
                        state_d = S_LOCK;
                        cap_d   = bc_n;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        fail_d  = ({{(32-AMP_W){1'b0}}, ba_n} < MIN_AMP_U);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign adc_req   = (state_q == S_SAMPLE);
    assign cap_code  = cap_q;
    assign best_code = bc_q;
    assign best_amp  = ba_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tank_tune_ctrl.sv
// Bench for tank_tune_ctrl: a sweep-schedule model predicts every output each
// cycle; directed scenarios pin peak, tie, stall, abort and reset behaviour.
module tb_tank_tune_ctrl;

    localparam int SETTLE = 16;
    localparam int NCODE  = 32;

    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_SETTLE = 3'd1;
    localparam logic [2:0] PH_SAMPLE = 3'd2;
    localparam logic [2:0] PH_EVAL   = 3'd3;
    localparam logic [2:0] PH_LOCK   = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       stray_ack = 1'b0;
    logic       adc_ack;
    logic [9:0] adc_data;
    logic       adc_req;
    logic [4:0] cap_code, best_code;
    logic [9:0] best_amp;
    logic       busy, done, fail;
    logic [2:0] dbg_state;

    int amp_tab   [NCODE];
    int delay_tab [NCODE];
    int wait_cnt = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    typedef struct packed {
        logic [4:0] cap;
        logic       req;
        logic       busy;
        logic       done;
        logic       fail;
        logic [9:0] ba;
        logic [4:0] bc;
        logic [2:0] ph;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur = '0;
    int   t0 = 0;

    tank_tune_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .adc_ack(adc_ack), .adc_data(adc_data), .adc_req(adc_req),
        .cap_code(cap_code), .best_code(best_code), .best_amp(best_amp),
        .busy(busy), .done(done), .fail(fail), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ADC responder: acks once req has been high for delay_tab[code] cycles.
    assign adc_data = 10'(amp_tab[cap_code]);
    assign adc_ack  = stray_ack | (adc_req && (wait_cnt == delay_tab[cap_code]));

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        wait_cnt <= adc_req ? wait_cnt + 1 : 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Expected cycle-by-cycle schedule of a whole sweep, from the start edge on.
    task automatic push_sweep();
        exp_t e;
        int   ba, bc;
        ba = 0;
        bc = 0;
        for (int c = 0; c < NCODE; c++) begin
            e = '0;
            e.cap = 5'(c); e.busy = 1'b1; e.ba = 10'(ba); e.bc = 5'(bc);
            e.ph = PH_SETTLE; e.req = 1'b0;
            for (int s = 0; s < SETTLE; s++) exp_q.push_back(e);
            e.ph = PH_SAMPLE; e.req = 1'b1;
            for (int s = 0; s <= delay_tab[c]; s++) exp_q.push_back(e);
            e.ph = PH_EVAL; e.req = 1'b0;
            exp_q.push_back(e);
            if (amp_tab[c] > ba) begin
                ba = amp_tab[c];
                bc = c;
            end
        end
        e = '0;
        e.cap = 5'(bc); e.done = 1'b1; e.fail = (ba < 64);
        e.ba = 10'(ba); e.bc = 5'(bc); e.ph = PH_LOCK;
        exp_q.push_back(e);
    endtask

    initial begin
        wait (chk_en);
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            chk("cap_code", cap_code, cur.cap);
            chk("adc_req", adc_req, cur.req);
            chk("busy", busy, cur.busy);
            chk("done", done, cur.done);
            chk("fail", fail, cur.fail);
            chk("best_amp", best_amp, cur.ba);
            chk("best_code", best_code, cur.bc);
        end
    end

    task automatic set_table(input int base, input int c1, input int a1, input int c2, input int a2);
        for (int i = 0; i < NCODE; i++) begin
            amp_tab[i]   = base;
            delay_tab[i] = 0;
        end
        amp_tab[c1] = a1;
        amp_tab[c2] = a2;
    endtask

    task automatic start_sweep(input logic with_abort);
        @(negedge clk); #2;
        start = 1'b1;
        abort = with_abort;
        if (!cur.busy) begin
            push_sweep();
            t0 = cyc + 1;
        end
        @(negedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_at(input int code, input logic [2:0] ph);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk); #2;
            if (cur.cap == 5'(code) && cur.ph == ph) got = 1'b1;
        end
        if (!got) timeout_fail("wait_at");
    endtask

    task automatic wait_lock(output int lat, output int req0_hi);
        logic got;
        got = 1'b0;
        req0_hi = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk); #1;
            if (adc_req === 1'b1 && cap_code == 5'd0) req0_hi++;
            if (done === 1'b1) got = 1'b1;
        end
        if (!got) timeout_fail("wait_lock");
        lat = cyc - t0;
    endtask

    task automatic chk_result(input string tag, input int lat_exp, input int bc, input int ba, input logic f);
        int lat, hi;
        wait_lock(lat, hi);
        chk({tag, "_latency"}, lat, lat_exp);
        chk({tag, "_best_code"}, best_code, bc);
        chk({tag, "_best_amp"}, best_amp, ba);
        chk({tag, "_cap_code"}, cap_code, bc);
        chk({tag, "_fail"}, fail, f);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int lat, hi;
        set_table(20, 13, 100, 13, 100);

        // reset state while rst is still asserted
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cap_code", cap_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_adc_req", adc_req, 0);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // peak sweep
        start_sweep(1'b0);
        chk_result("peak", 576, 13, 100, 1'b0);

        // tie and low level, restarted from LOCK
        set_table(10, 4, 50, 9, 50);
        start_sweep(1'b0);
        chk_result("tie", 576, 4, 50, 1'b1);

        // handshake stall at code 0 plus a stray ack during SETTLE
        set_table(20, 13, 100, 13, 100);
        delay_tab[0] = 7;
        start_sweep(1'b0);
        wait_at(0, PH_SETTLE);
        stray_ack = 1'b1;
        @(negedge clk); #2;
        stray_ack = 1'b0;
        wait_lock(lat, hi);
        chk("stall_req_high_cycles", hi, 8);
        chk("stall_latency", lat, 583);
        chk("stall_best_code", best_code, 13);
        chk("stall_best_amp", best_amp, 100);
        delay_tab[0] = 0;

        // abort in SETTLE of code 20
        start_sweep(1'b0);
        wait_at(20, PH_SETTLE);
        abort = 1'b1;
        exp_q.delete();
        cur.cap = cur.bc; cur.busy = 1'b0; cur.done = 1'b0;
        cur.fail = 1'b0; cur.req = 1'b0; cur.ph = PH_IDLE;
        @(negedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cap_code", cap_code, 13);
        chk("abort_best_amp", best_amp, 100);
        #1;
        abort = 1'b0;
        // abort in IDLE has no effect
        @(negedge clk); #2;
        abort = 1'b1;
        @(negedge clk); #2;
        abort = 1'b0;
        start_sweep(1'b0);
        chk("rescan_cap_code", cap_code, 0);
        chk("rescan_best_amp", best_amp, 0);
        chk("rescan_busy", busy, 1);
        chk_result("rescan", 576, 13, 100, 1'b0);

        // start+abort together in LOCK: start wins; then async reset in SAMPLE
        delay_tab[0] = 7;
        start_sweep(1'b1);
        wait_at(0, PH_SAMPLE);
        rst = 1'b1;
        exp_q.delete();
        cur = '0;
        #1;
        chk("async_rst_adc_req", adc_req, 0);
        chk("async_rst_cap_code", cap_code, 0);
        chk("async_rst_best_code", best_code, 0);
        chk("async_rst_best_amp", best_amp, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_fail", fail, 0);
        #1;
        rst = 1'b0;
        delay_tab[0] = 0;
        repeat (2) @(negedge clk);

        // start while busy is ignored
        start_sweep(1'b0);
        wait_at(5, PH_SETTLE);
        start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        chk_result("busy_start", 576, 13, 100, 1'b0);

        // start in LOCK restarts the sweep
        start_sweep(1'b0);
        chk("restart_busy", busy, 1);
        chk("restart_done", done, 0);
        chk("restart_cap_code", cap_code, 0);
        chk_result("restart", 576, 13, 100, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tank_tune_ctrl.md
TANK_TUNE_CTRL -- requirements
Module: tank_tune_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 5, width of the capacitor-bank tuning code for the LC tank.
REQ-002 SHALL have parameter AMP_W, default 10, width of the output-amplitude detector sample.
REQ-003 SHALL have parameter SETTLE, default 16, tank settling wait per code, in clk cycles (legal range 1..255).
REQ-004 SHALL have parameter MIN_AMP, default 64, minimum acceptable peak amplitude.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request a tuning sweep; single-cycle pulse or level.
REQ-008 abort  input  1  cancel a sweep in progress.
REQ-009 adc_ack  input  1  amplitude sample valid.
REQ-010 adc_data  input  AMP_W  detected output amplitude, unsigned.
REQ-011 adc_req  output  1  amplitude sample request.
REQ-012 cap_code  output  CODE_W  capacitor code currently driven to the tank.
REQ-013 best_code  output  CODE_W  code that produced the highest amplitude.
REQ-014 best_amp  output  AMP_W  highest amplitude recorded.
REQ-015 busy  output  1  sweep in progress.
REQ-016 done  output  1  sweep complete; held until the next sweep starts.
REQ-017 fail  output  1  qualifies done: best_amp < MIN_AMP.

Function
REQ-018 SHALL implement the states IDLE, SETTLE, SAMPLE, EVAL and LOCK.
REQ-019 IDLE or LOCK with start=1: next cycle SHALL enter SETTLE with cap_code=0, best_amp=0, best_code=0, done=0, fail=0 and busy=1.
REQ-020 SETTLE SHALL last exactly SETTLE cycles, counted by a down-counter, then enter SAMPLE.
REQ-021 SAMPLE SHALL assert adc_req every cycle until a cycle in which adc_ack=1.
  - adc_data is captured in the adc_ack cycle.
  - An ack in the first SAMPLE cycle is accepted.
  - adc_req SHALL be 0 in the cycle after the ack.
REQ-022 adc_ack received outside SAMPLE SHALL be ignored.
REQ-023 EVAL SHALL last one cycle.
  - If captured > best_amp (strict, unsigned), load best_amp and best_code := cap_code; ties keep the lower code.
REQ-024 EVAL exit: if cap_code < 2^CODE_W-1, increment cap_code and go to SETTLE; otherwise go to LOCK.
  - cap_code SHALL never wrap to 0 during a sweep.
REQ-025 Entering LOCK SHALL set cap_code := best_code, busy=0, done=1, and fail = (best_amp < MIN_AMP).
  - These values SHALL be held until the next start.
REQ-026 The comparison in REQ-025 SHALL use the best_amp value updated by the final EVAL.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort while busy SHALL take priority over any other event that cycle, with the following results next cycle:
  - state IDLE, adc_req=0, busy=0, done=0, fail=0;
  - cap_code := best_code;
  - best_code and best_amp keep their values.
REQ-029 abort in IDLE or LOCK SHALL have no effect.
REQ-030 start and abort both high in IDLE or LOCK: start SHALL win.
REQ-031 Sweep latency with zero-wait acks SHALL be 2^CODE_W × (SETTLE+2) cycles, measured from the first SETTLE cycle to the first LOCK cycle.

Reset
REQ-032 While rst=1, independent of clk, SHALL force:
  - state IDLE;
  - cap_code=0, best_code=0, best_amp=0;
  - adc_req=0, busy=0, done=0, fail=0;
  - settle counter cleared.
REQ-033 Reset asserted mid-sweep SHALL discard all sweep results.
  - First rising edge after rst deasserts: state stays IDLE unless start=1.

Verification
REQ-034 Peak sweep: defaults; ack same cycle as req; adc_data=100 at code 13, 20 at all other codes -> done=1, best_code=13, best_amp=100, cap_code=13, fail=0, latency 576 cycles.
REQ-035 Tie/low level: adc_data=50 at codes 4 and 9, 10 elsewhere -> best_code=4, best_amp=50, fail=1 (50<64).
REQ-036 Handshake stall: ack delayed 7 cycles at code 0 -> adc_req high 8 cycles, then low; stray ack during SETTLE ignored; sweep result unchanged.
REQ-037 Abort: abort asserted in SETTLE of code 20 with best_code=13 -> next cycle IDLE, busy=0, done=0, cap_code=13; a second start then rescans from code 0.
REQ-038 Async reset: rst pulse between clock edges while in SAMPLE -> all outputs 0 immediately, adc_req=0; start ignored while busy; start in LOCK restarts the sweep.
